// File: rtl/toggle_seq_pkg.sv
// Shared types and width helpers for the toggle sequencer.
package toggle_seq_pkg;

    typedef enum logic [1:0] {StIdle, StRun, StGap, StDone} state_e;

    // Bits needed to hold values 0..max_val, never less than one.
    function automatic int unsigned cnt_w(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/toggle_seq_ctrl_if.sv
// Control/status bundle between the button logic and the LED sequencer.
interface toggle_seq_ctrl_if #(
    parameter int unsigned NUM_CH = 4
) ();

    localparam int unsigned SelW = $clog2(NUM_CH);

    logic              i_Start;
    logic              i_Stop;
    logic              i_Loop;
    logic [SelW-1:0]   o_Sel;
    logic [NUM_CH-1:0] o_Ch;
    logic              o_Busy;
    logic              o_Done;

    modport master (
        output i_Start, i_Stop, i_Loop,
        input  o_Sel, o_Ch, o_Busy, o_Done
    );

    modport slave (
        input  i_Start, i_Stop, i_Loop,
        output o_Sel, o_Ch, o_Busy, o_Done
    );

endinterface

// File: rtl/toggle_seq_ctrl_tick_timer.sv
// Free-running divider: one-cycle tick every COUNT_LIMIT enabled clocks; clr_i zeroes it.
module tick_timer
    import toggle_seq_pkg::*;
#(
    parameter int unsigned COUNT_LIMIT = 10
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int unsigned     CntW   = cnt_w(COUNT_LIMIT - 1);
    localparam logic [CntW-1:0] CntMax = CntW'(COUNT_LIMIT - 1);

    logic [CntW-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= (cnt_q == CntMax) ? '0 : cnt_q + CntW'(1);
        end
    end

    assign tick_o = en_i && (cnt_q == CntMax);

endmodule

// File: rtl/toggle_seq_ctrl.sv
// Steps one blink timer across NUM_CH LED channels with a low gap between visits.
// Optional macro TOGGLE_SEQ_PINGPONG_EN: reverse direction at the ends instead of wrapping.
module toggle_seq_ctrl
    import toggle_seq_pkg::*;
#(
    parameter int unsigned NUM_CH         = 4,
    parameter int unsigned COUNT_LIMIT    = 10,
    parameter int unsigned TOGGLES_PER_CH = 4,
    parameter int unsigned GAP_CYCLES     = 5
) (
    input  logic             i_Clk,
    input  logic             i_Reset,
    toggle_seq_ctrl_if.slave bus
);

    localparam int unsigned     SelW    = $clog2(NUM_CH);
    localparam int unsigned     TogW    = cnt_w(TOGGLES_PER_CH);
    localparam int unsigned     GapW    = cnt_w(GAP_CYCLES - 1);
    localparam logic [SelW-1:0] SelLast = SelW'(NUM_CH - 1);
    localparam logic [TogW-1:0] TogLast = TogW'(TOGGLES_PER_CH - 1);
    localparam logic [GapW-1:0] GapLast = GapW'(GAP_CYCLES - 1);

    state_e            state_q;
    logic [SelW-1:0]   sel_q;
    logic [NUM_CH-1:0] ch_q;
    logic              busy_q;
    logic              done_q;
    logic [TogW-1:0]   tog_q;
    logic [GapW-1:0]   gap_q;
    logic              run_en;
    logic              tick_clr;
    logic              tick;
`ifdef TOGGLE_SEQ_PINGPONG_EN
    logic              rev_q;
`endif

    assign run_en   = (state_q == StRun);
    assign tick_clr = bus.i_Stop || !run_en;

    tick_timer #(
        .COUNT_LIMIT(COUNT_LIMIT)
    ) u_tick (
        .clk_i (i_Clk),
        .rst_i (i_Reset),
        .en_i  (run_en),
        .clr_i (tick_clr),
        .tick_o(tick)
    );

    always_ff @(posedge i_Clk) begin
        if (i_Reset || bus.i_Stop) begin
            state_q <= StIdle;
            sel_q   <= '0;
            ch_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            tog_q   <= '0;
            gap_q   <= '0;
`ifdef TOGGLE_SEQ_PINGPONG_EN
            rev_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.i_Start) begin
                        state_q <= StRun;
                        sel_q   <= '0;
                        tog_q   <= '0;
                        busy_q  <= 1'b1;
`ifdef TOGGLE_SEQ_PINGPONG_EN
                        rev_q   <= 1'b0;
`endif
                    end
                end
                StRun: begin
                    if (tick) begin
                        tog_q <= tog_q + TogW'(1);
                        // Final toggle is the falling one, so clearing all bits is equivalent.
                        if (tog_q == TogLast) begin
                            state_q <= StGap;
                            ch_q    <= '0;
                            gap_q   <= '0;
                        end else begin
                            ch_q[sel_q] <= ~ch_q[sel_q];
                        end
                    end
                end
                StGap: begin
                    if (gap_q != GapLast) begin
                        gap_q <= gap_q + GapW'(1);
                    end else begin
                        gap_q <= '0;
                        tog_q <= '0;
`ifdef TOGGLE_SEQ_PINGPONG_EN
                        if (!rev_q) begin
                            if (sel_q != SelLast) begin
                                sel_q   <= sel_q + SelW'(1);
                                state_q <= StRun;
                            end else if (bus.i_Loop) begin
                                rev_q   <= 1'b1;
                                sel_q   <= sel_q - SelW'(1);
                                state_q <= StRun;
                            end else begin
                                state_q <= StDone;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end
                        end else if (sel_q != '0) begin
                            sel_q   <= sel_q - SelW'(1);
                            state_q <= StRun;
                        end else begin
                            rev_q   <= 1'b0;
                            sel_q   <= sel_q + SelW'(1);
                            state_q <= StRun;
                        end
`else
                        if (sel_q != SelLast) begin
                            sel_q   <= sel_q + SelW'(1);
                            state_q <= StRun;
                        end else if (bus.i_Loop) begin
                            sel_q   <= '0;
                            state_q <= StRun;
                        end else begin
                            state_q <= StDone;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
`endif
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.o_Sel  = sel_q;
    assign bus.o_Ch   = ch_q;
    assign bus.o_Busy = busy_q;
    assign bus.o_Done = done_q;

endmodule

// File: tb/tb_toggle_seq_ctrl.sv
// Table-driven bench for toggle_seq_ctrl at default parameters.
module tb_toggle_seq_ctrl;

    localparam int unsigned NUM_CH = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    toggle_seq_ctrl_if #(.NUM_CH(NUM_CH)) bus ();

    toggle_seq_ctrl #(
        .NUM_CH        (NUM_CH),
        .COUNT_LIMIT   (10),
        .TOGGLES_PER_CH(4),
        .GAP_CYCLES    (5)
    ) dut (
        .i_Clk  (clk),
        .i_Reset(rst),
        .bus    (bus)
    );

    // Inputs applied at cycle cyc (held until the next row) and outputs expected in that cycle.
    typedef struct {
        int         cyc;
        logic       rst;
        logic       start;
        logic       stop;
        logic       loop;
        logic [1:0] sel;
        logic [3:0] ch;
        logic       busy;
        logic       done;
    } vec_t;

    vec_t tbl[$];
    int   errors = 0;
    int   checks = 0;

    task automatic add(input int cyc, input logic r, input logic s, input logic p, input logic l,
                       input logic [1:0] sel, input logic [3:0] ch, input logic busy,
                       input logic done);
        vec_t v;
        v.cyc = cyc; v.rst = r; v.start = s; v.stop = p; v.loop = l;
        v.sel = sel; v.ch = ch; v.busy = busy; v.done = done;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input int cyc, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        bus.i_Start = 1'b0;
        bus.i_Stop  = 1'b0;
        bus.i_Loop  = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic run_tbl(input string name);
        int         idx = 0;
        int         last = tbl[tbl.size()-1].cyc;
        logic [3:0] mask;
        for (int c = 0; c <= last; c++) begin
            if (idx < tbl.size() && tbl[idx].cyc == c) begin
                rst         = tbl[idx].rst;
                bus.i_Start = tbl[idx].start;
                bus.i_Stop  = tbl[idx].stop;
                bus.i_Loop  = tbl[idx].loop;
                check({name, ".sel"},  c, 32'(bus.o_Sel),  32'(tbl[idx].sel));
                check({name, ".ch"},   c, 32'(bus.o_Ch),   32'(tbl[idx].ch));
                check({name, ".busy"}, c, 32'(bus.o_Busy), 32'(tbl[idx].busy));
                check({name, ".done"}, c, 32'(bus.o_Done), 32'(tbl[idx].done));
                idx++;
            end
            mask = 4'b0001 << bus.o_Sel;
            check({name, ".onehot"}, c, 32'(bus.o_Ch & ~mask), 32'd0);
            if (!bus.o_Busy) check({name, ".idle_low"}, c, 32'(bus.o_Ch), 32'd0);
            step();
        end
        tbl.delete();
    endtask

    logic [1:0] wrap_sel;
    logic [3:0] wrap_ch;

    initial begin
`ifdef TOGGLE_SEQ_PINGPONG_EN
        wrap_sel = 2'd2;
        wrap_ch  = 4'b0100;
`else
        wrap_sel = 2'd0;
        wrap_ch  = 4'b0001;
`endif
        reset_dut();

        // Full pass, loop off; a stray start mid-RUN must not disturb timing.
        //   cyc  rst start stop loop sel ch busy done
        add(0,   0, 1, 0, 0, 2'd0, 4'b0000, 0, 0);
        add(1,   0, 0, 0, 0, 2'd0, 4'b0000, 1, 0);
        add(10,  0, 0, 0, 0, 2'd0, 4'b0000, 1, 0);
        add(11,  0, 0, 0, 0, 2'd0, 4'b0001, 1, 0);
        add(20,  0, 1, 0, 0, 2'd0, 4'b0001, 1, 0);
        add(21,  0, 0, 0, 0, 2'd0, 4'b0000, 1, 0);
        add(31,  0, 0, 0, 0, 2'd0, 4'b0001, 1, 0);
        add(40,  0, 0, 0, 0, 2'd0, 4'b0001, 1, 0);
        add(41,  0, 0, 0, 0, 2'd0, 4'b0000, 1, 0);
        add(45,  0, 0, 0, 0, 2'd0, 4'b0000, 1, 0);
        add(46,  0, 0, 0, 0, 2'd1, 4'b0000, 1, 0);
        add(56,  0, 0, 0, 0, 2'd1, 4'b0010, 1, 0);
        add(91,  0, 0, 0, 0, 2'd2, 4'b0000, 1, 0);
        add(101, 0, 0, 0, 0, 2'd2, 4'b0100, 1, 0);
        add(136, 0, 0, 0, 0, 2'd3, 4'b0000, 1, 0);
        add(146, 0, 0, 0, 0, 2'd3, 4'b1000, 1, 0);
        add(175, 0, 0, 0, 0, 2'd3, 4'b1000, 1, 0);
        add(176, 0, 0, 0, 0, 2'd3, 4'b0000, 1, 0);
        add(180, 0, 0, 0, 0, 2'd3, 4'b0000, 1, 0);
        add(181, 0, 0, 0, 0, 2'd3, 4'b0000, 0, 1);
        add(182, 0, 0, 0, 0, 2'd3, 4'b0000, 0, 0);
        add(185, 0, 0, 0, 0, 2'd3, 4'b0000, 0, 0);
        run_tbl("single");

        // Loop on, then abort with stop.
        reset_dut();
        add(0,   0, 1, 0, 1, 2'd0, 4'b0000, 0, 0);
        add(1,   0, 0, 0, 1, 2'd0, 4'b0000, 1, 0);
        add(180, 0, 0, 0, 1, 2'd3, 4'b0000, 1, 0);
        add(181, 0, 0, 0, 1, wrap_sel, 4'b0000, 1, 0);
        add(191, 0, 0, 0, 1, wrap_sel, wrap_ch, 1, 0);
        add(200, 0, 0, 1, 1, wrap_sel, wrap_ch, 1, 0);
        add(201, 0, 0, 0, 1, 2'd0, 4'b0000, 0, 0);
        add(215, 0, 0, 0, 1, 2'd0, 4'b0000, 0, 0);
        run_tbl("loop");

        // Start and stop together: stop wins, nothing starts.
        reset_dut();
        add(0,  0, 1, 1, 0, 2'd0, 4'b0000, 0, 0);
        add(3,  0, 1, 1, 0, 2'd0, 4'b0000, 0, 0);
        add(6,  0, 0, 0, 0, 2'd0, 4'b0000, 0, 0);
        add(8,  0, 0, 0, 0, 2'd0, 4'b0000, 0, 0);
        run_tbl("startstop");

        // Reset mid-sequence, then a fresh start with full timing.
        reset_dut();
        add(0,   0, 1, 0, 0, 2'd0, 4'b0000, 0, 0);
        add(1,   0, 0, 0, 0, 2'd0, 4'b0000, 1, 0);
        add(56,  0, 0, 0, 0, 2'd1, 4'b0010, 1, 0);
        add(60,  1, 0, 0, 0, 2'd1, 4'b0010, 1, 0);
        add(61,  0, 0, 0, 0, 2'd0, 4'b0000, 0, 0);
        add(70,  0, 1, 0, 0, 2'd0, 4'b0000, 0, 0);
        add(71,  0, 0, 0, 0, 2'd0, 4'b0000, 1, 0);
        add(80,  0, 0, 0, 0, 2'd0, 4'b0000, 1, 0);
        add(81,  0, 0, 0, 0, 2'd0, 4'b0001, 1, 0);
        add(115, 0, 0, 0, 0, 2'd0, 4'b0000, 1, 0);
        add(116, 0, 0, 0, 0, 2'd1, 4'b0000, 1, 0);
        run_tbl("midreset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
